// File: rtl/gon_tag_scheduler_pkg.sv
// Purpose : shared GON scheduler types - FSM state encoding and default field widths.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package gon_tag_scheduler_pkg;

   // Default width of the tag-count and beat-count fields.
   localparam int GON_CNT_BITS = 8;

   // Default width of the id/tag buses when no XID_BITS define is supplied.
   localparam int GON_XID_BITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PROG   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } gon_state_e;

endpackage

// File: rtl/gon_tag_scheduler_if.sv
// Purpose : upstream/GON-bus handshake bundle plus the multicast tag.
// Latency : n/a (wires only).
// Backpr. : bus_ready flows back to up_ready through the scheduler while streaming.
// Ports   : up_valid/up_ready (upstream side), bus_valid/bus_ready (GON side), tag.
//           master = scheduler view, slave = environment view.
interface gon_tag_scheduler_if
   import gon_tag_scheduler_pkg::*;
#(
   parameter int ID_SIZE = GON_XID_BITS
) ();

   logic               up_valid;
   logic               up_ready;
   logic               bus_valid;
   logic               bus_ready;
   logic [ID_SIZE-1:0] tag;

   modport master (
      input  up_valid,
      input  bus_ready,
      output up_ready,
      output bus_valid,
      output tag
   );

   modport slave (
      output up_valid,
      output bus_ready,
      input  up_ready,
      input  bus_valid,
      input  tag
   );

endinterface

// File: rtl/gon_tag_scheduler.sv
// Purpose : programs NUM_PE GON targets with consecutive ids, then streams
//           tag_count x beats upstream beats onto the GON bus under a walking tag.
// Latency : streaming path is purely combinational (zero added cycles).
// Backpr. : bus_ready passes straight to up_ready; a stalled beat waits indefinitely.
// Ports   : clk/rst, start/abort control, cfg_* run parameters (latched at start),
//           set_id/id_out target programming, bus (handshake + tag), busy/done status.

`ifndef XID_BITS
`define XID_BITS 8
`endif

module gon_tag_scheduler
   import gon_tag_scheduler_pkg::*;
#(
   parameter int NUM_PE   = 8,
   parameter int ID_SIZE  = `XID_BITS,
   parameter int CNT_BITS = GON_CNT_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [ID_SIZE-1:0]  cfg_id_base,
   input  logic [ID_SIZE-1:0]  cfg_tag_base,
   input  logic [CNT_BITS-1:0] cfg_tag_count,
   input  logic [CNT_BITS-1:0] cfg_beats,
   output logic [NUM_PE-1:0]   set_id,
   output logic [ID_SIZE-1:0]  id_out,
   gon_tag_scheduler_if.master bus,
   output logic                busy,
   output logic                done
);

   localparam int                PW        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [PW-1:0]     PROG_LAST = PW'(NUM_PE - 1);
   localparam logic [PW-1:0]     PROG_ONE  = PW'(1);
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [NUM_PE-1:0] SEL_ONE   = NUM_PE'(1);

   gon_state_e          state_q, state_d;
   logic [PW-1:0]       prog_cnt_q, prog_cnt_d;
   logic [ID_SIZE-1:0]  id_base_q, id_base_d;
   logic [ID_SIZE-1:0]  tag_base_q, tag_base_d;
   logic [CNT_BITS-1:0] tag_cnt_q, tag_cnt_d;
   logic [CNT_BITS-1:0] beats_q, beats_d;
   logic [CNT_BITS-1:0] beat_idx_q, beat_idx_d;
   logic [CNT_BITS-1:0] tag_idx_q, tag_idx_d;

   logic               bus_valid_c;
   logic               up_ready_c;
   logic [ID_SIZE-1:0] tag_c;
   logic               beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prog_cnt_q <= '0;
         id_base_q  <= '0;
         tag_base_q <= '0;
         tag_cnt_q  <= '0;
         beats_q    <= '0;
         beat_idx_q <= '0;
         tag_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         prog_cnt_q <= prog_cnt_d;
         id_base_q  <= id_base_d;
         tag_base_q <= tag_base_d;
         tag_cnt_q  <= tag_cnt_d;
         beats_q    <= beats_d;
         beat_idx_q <= beat_idx_d;
         tag_idx_q  <= tag_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      prog_cnt_d  = prog_cnt_q;
      id_base_d   = id_base_q;
      tag_base_d  = tag_base_q;
      tag_cnt_d   = tag_cnt_q;
      beats_d     = beats_q;
      beat_idx_d  = beat_idx_q;
      tag_idx_d   = tag_idx_q;
      set_id      = '0;
      id_out      = '0;
      tag_c       = '0;
      bus_valid_c = 1'b0;
      up_ready_c  = 1'b0;
      done        = 1'b0;
      beat        = 1'b0;

      case (state_q)
         IDLE: begin
            // abort outranks start, so an abort in IDLE swallows the request.
            if (start && !abort) begin
               id_base_d  = cfg_id_base;
               tag_base_d = cfg_tag_base;
               tag_cnt_d  = cfg_tag_count;
               beats_d    = cfg_beats;
               prog_cnt_d = '0;
               beat_idx_d = '0;
               tag_idx_d  = '0;
               state_d    = PROG;
            end
         end

         PROG: begin
            set_id = SEL_ONE << prog_cnt_q;
            id_out = id_base_q + ID_SIZE'(prog_cnt_q);
            if (abort) begin
               prog_cnt_d = '0;
               state_d    = IDLE;
            end else if (prog_cnt_q == PROG_LAST) begin
               prog_cnt_d = '0;
               // A zero-sized run has nothing to stream; finish straight away.
               state_d    = (tag_cnt_q != '0 && beats_q != '0) ? STREAM : DONE;
            end else begin
               prog_cnt_d = prog_cnt_q + PROG_ONE;
            end
         end

         STREAM: begin
            if (abort) begin
               // Handshake is withheld in the abort cycle so no beat can be
               // transferred that the counters would not account for.
               beat_idx_d = '0;
               tag_idx_d  = '0;
               state_d    = IDLE;
            end else begin
               bus_valid_c = bus.up_valid;
               up_ready_c  = bus.bus_ready;
               tag_c       = tag_base_q + ID_SIZE'(tag_idx_q);
               beat        = bus.up_valid && bus.bus_ready;
               if (beat) begin
                  if (beat_idx_q == beats_q - CNT_ONE) begin
                     beat_idx_d = '0;
                     if (tag_idx_q == tag_cnt_q - CNT_ONE) begin
                        tag_idx_d = '0;
                        state_d   = DONE;
                     end else begin
                        tag_idx_d = tag_idx_q + CNT_ONE;
                     end
                  end else begin
                     beat_idx_d = beat_idx_q + CNT_ONE;
                  end
               end
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy          = (state_q != IDLE);
   assign bus.bus_valid = bus_valid_c;
   assign bus.up_ready  = up_ready_c;
   assign bus.tag       = tag_c;

endmodule

// File: tb/tb_gon_tag_scheduler.sv
// Purpose : self-checking bench for gon_tag_scheduler (NUM_PE=8, ID_SIZE=4).
// Latency : expected tags queued at run start, popped on each observed beat.
// Backpr. : bench toggles bus_ready/up_valid to exercise stalls.
module tb_gon_tag_scheduler;

   localparam int NUM_PE   = 8;
   localparam int ID_SIZE  = 4;
   localparam int CNT_BITS = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                start;
   logic                abort;
   logic [ID_SIZE-1:0]  cfg_id_base;
   logic [ID_SIZE-1:0]  cfg_tag_base;
   logic [CNT_BITS-1:0] cfg_tag_count;
   logic [CNT_BITS-1:0] cfg_beats;
   logic [NUM_PE-1:0]   set_id;
   logic [ID_SIZE-1:0]  id_out;
   logic                busy;
   logic                done;

   gon_tag_scheduler_if #(.ID_SIZE(ID_SIZE)) bus_if ();

   gon_tag_scheduler #(
      .NUM_PE  (NUM_PE),
      .ID_SIZE (ID_SIZE),
      .CNT_BITS(CNT_BITS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .cfg_id_base  (cfg_id_base),
      .cfg_tag_base (cfg_tag_base),
      .cfg_tag_count(cfg_tag_count),
      .cfg_beats    (cfg_beats),
      .set_id       (set_id),
      .id_out       (id_out),
      .bus          (bus_if.master),
      .busy         (busy),
      .done         (done)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   logic [ID_SIZE-1:0] exp_tags[$];

   // Drive start with a config; the cycle after, cfg is scrambled to prove it was latched.
   task automatic do_start(input logic [ID_SIZE-1:0] idb, input logic [ID_SIZE-1:0] tgb,
                           input logic [CNT_BITS-1:0] tc, input logic [CNT_BITS-1:0] bt);
      @(negedge clk);
      cfg_id_base   = idb;
      cfg_tag_base  = tgb;
      cfg_tag_count = tc;
      cfg_beats     = bt;
      start         = 1'b1;
      abort         = 1'b0;
   endtask

   task automatic scramble_cfg();
      cfg_id_base   = ~cfg_id_base;
      cfg_tag_base  = ~cfg_tag_base;
      cfg_tag_count = 8'd0;
      cfg_beats     = 8'd0;
   endtask

   task automatic skip_prog();
      for (int i = 0; i < NUM_PE; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 0) scramble_cfg();
      end
   endtask

   task automatic push_run(input logic [ID_SIZE-1:0] tgb, input int tc, input int bt);
      logic [ID_SIZE-1:0] t;
      for (int k = 0; k < tc; k++) begin
         t = tgb + ID_SIZE'(k);
         for (int b = 0; b < bt; b++) exp_tags.push_back(t);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
      cfg_id_base = '0; cfg_tag_base = '0; cfg_tag_count = '0; cfg_beats = '0;
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if ({set_id, id_out, bus_if.tag} !== '0) begin
         tests_failed++;
         $display("FAIL reset_bus: set_id/id_out/tag got %0h/%0h/%0h required 0", set_id, id_out, bus_if.tag);
      end
      tests_run++;
      if ({bus_if.bus_valid, bus_if.up_ready, busy, done} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_ctl: bus_valid,up_ready,busy,done got %b required 0000",
                  {bus_if.bus_valid, bus_if.up_ready, busy, done});
      end
      @(negedge clk);
      rst = 1'b0; bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_prog();
      logic [NUM_PE-1:0]  one;
      logic [NUM_PE-1:0]  es;
      logic [ID_SIZE-1:0] ei;
      one = 1;
      do_start(4'd3, 4'd5, 8'd3, 8'd2);
      for (int i = 0; i < NUM_PE; i++) begin
         @(negedge clk);
         start = (i == 2);
         if (i == 0) scramble_cfg();
         #1;
         es = one << i;
         ei = ID_SIZE'(3 + i);
         tests_run++;
         if (set_id !== es || id_out !== ei || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL prog_cycle%0d: set_id/id_out/busy got %0h/%0d/%b required %0h/%0d/1",
                     i, set_id, id_out, busy, es, ei);
         end
      end
      @(negedge clk);
      start = 1'b0; bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b0;
      #1;
      tests_run++;
      if (bus_if.bus_valid !== 1'b1 || bus_if.up_ready !== 1'b0 || bus_if.tag !== 4'd5 || set_id !== '0) begin
         tests_failed++;
         $display("FAIL prog_to_stream: bus_valid/up_ready/tag/set_id got %b/%b/%0d/%0h required 1/0/5/0",
                  bus_if.bus_valid, bus_if.up_ready, bus_if.tag, set_id);
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; bus_if.up_valid = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL prog_abort_idle: busy/done got %b/%b required 0/0", busy, done);
      end
   endtask

   task automatic test_backpressure();
      int nbeats;
      logic [ID_SIZE-1:0] e;
      exp_tags.delete();
      do_start(4'd3, 4'd5, 8'd3, 8'd2);
      push_run(4'd5, 3, 2);
      skip_prog();
      nbeats = 0;
      for (int cyc = 0; cyc < 80 && nbeats < 6; cyc++) begin
         @(negedge clk);
         bus_if.up_valid  = (cyc % 5) != 3;
         bus_if.bus_ready = cyc[0];
         #1;
         tests_run++;
         if (bus_if.bus_valid !== bus_if.up_valid || bus_if.up_ready !== bus_if.bus_ready) begin
            tests_failed++;
            $display("FAIL bp_passthru cyc%0d: bus_valid/up_ready got %b/%b required %b/%b",
                     cyc, bus_if.bus_valid, bus_if.up_ready, bus_if.up_valid, bus_if.bus_ready);
         end
         if (bus_if.bus_valid && bus_if.bus_ready) begin
            nbeats++;
            tests_run++;
            if (exp_tags.size() == 0) begin
               tests_failed++;
               $display("FAIL bp_extra_beat: got beat %0d required none", nbeats);
            end else begin
               e = exp_tags.pop_front();
               if (bus_if.tag !== e) begin
                  tests_failed++;
                  $display("FAIL bp_tag beat%0d: got %0d required %0d", nbeats, bus_if.tag, e);
               end
            end
         end
      end
      tests_run++;
      if (nbeats != 6) begin
         tests_failed++;
         $display("FAIL bp_timeout: got %0d beats required 6", nbeats);
      end
      @(negedge clk);
      start = 1'b1; bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
      #1;
      tests_run++;
      if (done !== 1'b1 || bus_if.bus_valid !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_done: done/bus_valid/busy got %b/%b/%b required 1/0/1", done, bus_if.bus_valid, busy);
      end
      @(negedge clk);
      start = 1'b0; bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
      #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || exp_tags.size() != 0) begin
         tests_failed++;
         $display("FAIL bp_after_done: done/busy/left got %b/%b/%0d required 0/0/0", done, busy, exp_tags.size());
      end
   endtask

   task automatic test_zero_bypass();
      logic bv_seen;
      bv_seen = 1'b0;
      do_start(4'd3, 4'd5, 8'd3, 8'd0);
      for (int i = 0; i < NUM_PE; i++) begin
         @(negedge clk);
         start = 1'b0; bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
         #1;
         if (bus_if.bus_valid) bv_seen = 1'b1;
      end
      @(negedge clk);
      #1;
      if (bus_if.bus_valid) bv_seen = 1'b1;
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL bypass_done: got %b required 1", done);
      end
      @(negedge clk);
      #1;
      if (bus_if.bus_valid) bv_seen = 1'b1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bypass_idle: done/busy got %b/%b required 0/0", done, busy);
      end
      tests_run++;
      if (bv_seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL bypass_bus_valid: got %b required 0", bv_seen);
      end
      bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int nbeats;
      logic [ID_SIZE-1:0] ei;
      logic [ID_SIZE-1:0] e;
      exp_tags.delete();
      do_start(4'd14, 4'd15, 8'd2, 8'd1);
      push_run(4'd15, 2, 1);
      for (int i = 0; i < NUM_PE; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         ei = ID_SIZE'(14 + i);
         tests_run++;
         if (id_out !== ei) begin
            tests_failed++;
            $display("FAIL wrap_id%0d: got %0d required %0d", i, id_out, ei);
         end
      end
      nbeats = 0;
      for (int cyc = 0; cyc < 10 && nbeats < 2; cyc++) begin
         @(negedge clk);
         bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
         #1;
         if (bus_if.bus_valid && bus_if.bus_ready) begin
            nbeats++;
            e = exp_tags.pop_front();
            tests_run++;
            if (bus_if.tag !== e) begin
               tests_failed++;
               $display("FAIL wrap_tag beat%0d: got %0d required %0d", nbeats, bus_if.tag, e);
            end
         end
      end
      @(negedge clk);
      bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
      #1;
      tests_run++;
      if (nbeats != 2 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_done: beats/done got %0d/%b required 2/1", nbeats, done);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int nbeats;
      logic [ID_SIZE-1:0] e;
      exp_tags.delete();
      do_start(4'd3, 4'd5, 8'd3, 8'd2);
      push_run(4'd5, 3, 2);
      skip_prog();
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
         #1;
         e = exp_tags.pop_front();
         tests_run++;
         if (bus_if.bus_valid !== 1'b1 || bus_if.tag !== e) begin
            tests_failed++;
            $display("FAIL abort_pre beat%0d: bus_valid/tag got %b/%0d required 1/%0d", b, bus_if.bus_valid, bus_if.tag, e);
         end
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || bus_if.tag !== '0 || bus_if.bus_valid !== 1'b0 || bus_if.up_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_idle: busy/done/tag/bus_valid/up_ready got %b/%b/%0d/%b/%b required 0/0/0/0/0",
                  busy, done, bus_if.tag, bus_if.bus_valid, bus_if.up_ready);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %b required 0", done);
      end
      exp_tags.delete();
      do_start(4'd3, 4'd5, 8'd3, 8'd2);
      push_run(4'd5, 3, 2);
      skip_prog();
      nbeats = 0;
      for (int cyc = 0; cyc < 20 && nbeats < 6; cyc++) begin
         @(negedge clk);
         bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
         #1;
         if (bus_if.bus_valid && bus_if.bus_ready) begin
            nbeats++;
            e = exp_tags.pop_front();
            tests_run++;
            if (bus_if.tag !== e) begin
               tests_failed++;
               $display("FAIL abort_rerun_tag beat%0d: got %0d required %0d", nbeats, bus_if.tag, e);
            end
         end
      end
      @(negedge clk);
      bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
      #1;
      tests_run++;
      if (nbeats != 6 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_rerun_done: beats/done got %0d/%b required 6/1", nbeats, done);
      end
      @(negedge clk);
   endtask

   task automatic test_rst_mid_prog();
      do_start(4'd3, 4'd5, 8'd3, 8'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = (i == 1);
      end
      @(negedge clk);
      start = 1'b0; rst = 1'b1;
      #1;
      tests_run++;
      if (set_id !== 8'h10) begin
         tests_failed++;
         $display("FAIL rst_at_prog4: set_id got %0h required 10", set_id);
      end
      @(negedge clk);
      rst = 1'b0; bus_if.up_valid = 1'b1; bus_if.bus_ready = 1'b1;
      #1;
      tests_run++;
      if ({set_id, id_out, bus_if.tag, bus_if.bus_valid, bus_if.up_ready, busy, done} !== '0) begin
         tests_failed++;
         $display("FAIL rst_outputs: set_id/id_out/tag/bv/ur/busy/done got %0h/%0d/%0d/%b/%b/%b/%b required all 0",
                  set_id, id_out, bus_if.tag, bus_if.bus_valid, bus_if.up_ready, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         tests_run++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_quiet%0d: done/busy got %b/%b required 0/0", i, done, busy);
         end
      end
      bus_if.up_valid = 1'b0; bus_if.bus_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prog();
      test_backpressure();
      test_zero_bypass();
      test_wrap();
      test_abort();
      test_rst_mid_prog();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard stop in case a task ever stalls on the clock.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gon_tag_scheduler.md
GON_TAG_SCHEDULER -- requirements
Module: gon_tag_scheduler

Interface
REQ-001 SHALL have parameter NUM_PE, default 8: number of GON multicast targets programmed per run.
REQ-002 SHALL have parameter ID_SIZE, default `XID_BITS: width of id and tag buses.
REQ-003 SHALL have parameter CNT_BITS, default 8: width of tag-count and beat-count fields.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle run request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  synchronous run cancel.
REQ-008 SHALL have ports cfg_id_base (ID_SIZE), cfg_tag_base (ID_SIZE), cfg_tag_count (CNT_BITS) and cfg_beats (CNT_BITS), all inputs, holding run parameters.
REQ-009 SHALL have port set_id  output  NUM_PE  one-hot ID-load strobe per target.
REQ-010 SHALL have port id_out  output  ID_SIZE  ID value broadcast to targets.
REQ-011 SHALL have port tag  output  ID_SIZE  current multicast tag.
REQ-012 SHALL have ports up_valid (input) and up_ready (output), 1 bit each: upstream handshake.
REQ-013 SHALL have ports bus_valid (output) and bus_ready (input), 1 bit each: GON bus handshake.
REQ-014 SHALL have ports busy and done, outputs, 1 bit each: busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, PROG, STREAM and DONE.
REQ-016 SHALL, in IDLE with start=1, latch all cfg_* inputs into internal registers and enter PROG next cycle; cfg_* SHALL be ignored at all other times.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL, in PROG, spend exactly NUM_PE cycles; in cycle i, set_id = 1<<i and id_out = id_base+i, truncated modulo 2^ID_SIZE.
REQ-019 SHALL hold set_id = 0 and id_out = 0 outside PROG.
REQ-020 SHALL, after the last PROG cycle, enter STREAM if tag_count!=0 and beats!=0, else enter DONE.
REQ-021 SHALL, in STREAM, drive bus_valid = up_valid, up_ready = bus_ready and tag = tag_base+tag_idx (mod 2^ID_SIZE), all combinationally; zero cycles of added latency.
REQ-022 SHALL define a beat as up_valid && bus_ready in STREAM, and SHALL increment beat_idx on each beat.
REQ-023 SHALL, on the beat where beat_idx == beats-1, clear beat_idx and increment tag_idx; tag SHALL change on the following cycle.
REQ-024 SHALL enter DONE on the beat completing tag_idx == tag_count-1 and beat_idx == beats-1.
REQ-025 SHALL hold bus_valid = 0 and up_ready = 0 outside STREAM; tag SHALL read 0 outside STREAM.
REQ-026 SHALL assert done for exactly the one DONE cycle, then return to IDLE; start in the DONE cycle SHALL be ignored.
REQ-027 SHALL, on abort in PROG or STREAM, return to IDLE next cycle without a done pulse, without counting a beat in the abort cycle, and with every output at its reset value.
REQ-028 SHALL give rst priority over abort, and abort priority over start.
REQ-029 SHALL treat a stalled beat (up_valid=1, bus_ready=0) as no progress, with no timeout.

Reset
REQ-030 SHALL, on rst, enter IDLE and clear all counters and latched config; set_id, id_out, tag, bus_valid, up_ready, busy and done SHALL read 0.
REQ-031 SHALL, on rst mid-run, abandon the run with no done pulse.

Structure
REQ-032 SHALL take the FSM state enum and the CNT_BITS default from the shared GON package; ID_SIZE SHALL come from define.svh.
REQ-033 SHALL be a single module with no sub-modules; the one-hot set_id SHALL be decoded from a $clog2(NUM_PE)-bit PROG counter.

Verification
REQ-034 SHALL verify programming: NUM_PE=8, cfg_id_base=3 -> set_id walks 0x01..0x80 over 8 cycles with id_out 3..10, then STREAM.
REQ-035 SHALL verify streaming with backpressure: tag_base=5, tag_count=3, beats=2, bus_ready toggling -> exactly 6 beats, tag sequence 5,5,6,6,7,7, done one cycle after the 6th beat.
REQ-036 SHALL verify zero-count bypass: cfg_beats=0 -> PROG (8 cycles) -> DONE -> IDLE with bus_valid never asserted.
REQ-037 SHALL verify wrap: ID_SIZE=4, cfg_id_base=14 -> id_out 14,15,0,1,...; tag_base=15, tag_count=2 -> tags 15,0.
REQ-038 SHALL verify abort mid-STREAM after 3 of 6 beats -> IDLE next cycle, no done; a new start then runs from tag_base.
REQ-039 SHALL verify rst asserted in PROG cycle 4 -> all outputs 0 next cycle; start during busy has no effect.
